es8388_cfg_sequencer: RTL and testbench

Sequences the ES8388 codec power-up configuration. It walks a register table of {reg_addr, reg_data} pairs and issues one I2C byte-write request per entry to the shared I2C write engine. It retries NACKed writes, inserts a settling gap between writes, and reports completion or failure. It sits between the power-up delay/Go pulse logic and the I2C bit engine in the audio loopback design.

---
 rtl/es8388_cfg_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_es8388_cfg_sequencer.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/es8388_cfg_sequencer.sv
// ES8388 power-up configuration sequencer.
// Walks a {reg_addr, reg_data} table and issues one I2C byte write per entry
// to the shared write engine. NACKed writes are retried. A settling gap
// follows every completed write. The sequencer reports completion or the
// index of the entry that failed.
module es8388_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR   = 7'h10,
    parameter int         NUM_REGS   = 32,
    parameter int         IDX_W      = 6,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_CYCLES = 500
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Go,
    output logic [IDX_W-1:0] Tbl_Addr,
    input  logic [15:0]      Tbl_Data,
    output logic             Wr_Req,
    output logic [6:0]       Wr_Dev,
    output logic [7:0]       Wr_Reg,
    output logic [7:0]       Wr_Data,
    input  logic             Wr_Ack,
    input  logic             Wr_Done,
    input  logic             Wr_Nack,
    output logic             Busy,
    output logic             Init_Done,
    output logic             Init_Err,
    output logic [IDX_W-1:0] Err_Index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);
    localparam logic [15:0]      GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t           state_reg,      state_next;
    logic [IDX_W-1:0] idx_reg,        idx_next;
    logic [2:0]       retry_reg,      retry_next;
    logic             retry_flag_reg, retry_flag_next;
    logic [15:0]      gap_reg,        gap_next;
    logic [7:0]       reg_addr_reg,   reg_addr_next;
    logic [7:0]       reg_data_reg,   reg_data_next;
    logic             done_reg,       done_next;
    logic             err_reg,        err_next;
    logic [IDX_W-1:0] err_idx_reg,    err_idx_next;

    // The engine can report completion in the same cycle it accepts the
    // request; that case is handled exactly like an ack followed by a done.
    logic xfer_end;
    assign xfer_end = ((state_reg == S_WAIT) && Wr_Done) ||
                      ((state_reg == S_REQ) && Wr_Ack && Wr_Done);

    // State register and datapath registers; reset drops Wr_Req immediately.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            retry_reg      <= '0;
            retry_flag_reg <= 1'b0;
            gap_reg        <= '0;
            reg_addr_reg   <= '0;
            reg_data_reg   <= '0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            err_idx_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            retry_reg      <= retry_next;
            retry_flag_reg <= retry_flag_next;
            gap_reg        <= gap_next;
            reg_addr_reg   <= reg_addr_next;
            reg_data_reg   <= reg_data_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            err_idx_reg    <= err_idx_next;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        retry_next      = retry_reg;
        retry_flag_next = retry_flag_reg;
        gap_next        = gap_reg;
        reg_addr_next   = reg_addr_reg;
        reg_data_next   = reg_data_reg;
        done_next       = done_reg;
        err_next        = err_reg;
        err_idx_next    = err_idx_reg;

        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Go) begin
                    done_next       = 1'b0;
                    err_next        = 1'b0;
                    idx_next        = '0;
                    retry_next      = '0;
                    retry_flag_next = 1'b0;
                    gap_next        = '0;
                    state_next      = S_FETCH;
                end
            end
            S_FETCH: begin
                // Table read has one cycle of latency after Tbl_Addr moves.
                state_next = S_LATCH;
            end
            S_LATCH: begin
                reg_addr_next = Tbl_Data[15:8];
                reg_data_next = Tbl_Data[7:0];
                state_next    = S_REQ;
            end
            S_REQ: begin
                if (Wr_Ack) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                state_next = S_WAIT;
            end
            S_GAP: begin
                if (gap_reg == GAP_LAST) begin
                    gap_next = '0;
                    if (retry_flag_reg) begin
                        // Re-request the same latched entry, no re-fetch.
                        retry_flag_next = 1'b0;
                        state_next      = S_REQ;
                    end else if (idx_reg == LAST_IDX) begin
                        done_next  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = S_FETCH;
                    end
                end else begin
                    gap_next = gap_reg + 16'd1;
                end
            end
        endcase

        // Completion of a write decides between next entry, retry or failure.
        if (xfer_end) begin
            gap_next = '0;
            if (!Wr_Nack) begin
                retry_next = '0;
                state_next = S_GAP;
            end else if (retry_reg < RETRY_MAX) begin
                retry_next      = retry_reg + 3'd1;
                retry_flag_next = 1'b1;
                state_next      = S_GAP;
            end else begin
                err_idx_next = idx_reg;
                err_next     = 1'b1;
                state_next   = S_ERROR;
            end
        end
    end

    // Output decode from state and registers.
    always_comb begin
        Wr_Req    = (state_reg == S_REQ);
        Busy      = !((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                      (state_reg == S_ERROR));
        Tbl_Addr  = idx_reg;
        Wr_Dev    = DEV_ADDR;
        Wr_Reg    = reg_addr_reg;
        Wr_Data   = reg_data_reg;
        Init_Done = done_reg;
        Init_Err  = err_reg;
        Err_Index = err_idx_reg;
    end

endmodule

// File: tb/tb_es8388_cfg_sequencer.sv
// Bench for the ES8388 configuration sequencer. A small table ROM and an
// I2C engine model drive the DUT; each test pushes the write requests it
// expects onto a queue and pops them as the DUT issues them.
module tb_es8388_cfg_sequencer;

    localparam int         IDX_W      = 6;
    localparam int         NUM_REGS   = 4;
    localparam int         MAX_RETRY  = 3;
    localparam int         GAP_CYCLES = 4;
    localparam logic [6:0] DEV_ADDR   = 7'h10;
    localparam int         ACK_DLY    = 2;
    localparam int         DONE_DLY   = 10;
    localparam int         TMO        = 200;

    logic             Clk;
    logic             Rst_n;
    logic             Go;
    logic [IDX_W-1:0] Tbl_Addr;
    logic [15:0]      Tbl_Data;
    logic             Wr_Req;
    logic [6:0]       Wr_Dev;
    logic [7:0]       Wr_Reg;
    logic [7:0]       Wr_Data;
    logic             Wr_Ack;
    logic             Wr_Done;
    logic             Wr_Nack;
    logic             Busy;
    logic             Init_Done;
    logic             Init_Err;
    logic [IDX_W-1:0] Err_Index;

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        logic       nack;
        logic       same;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [15:0] tbl [0:(1<<IDX_W)-1];
    int          errors = 0;
    int          checks = 0;
    logic        ok;
    int          n;
    logic        pulse_en;
    logic        seen;

    es8388_cfg_sequencer #(
        .DEV_ADDR  (DEV_ADDR),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .MAX_RETRY (MAX_RETRY),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Go       (Go),
        .Tbl_Addr (Tbl_Addr),
        .Tbl_Data (Tbl_Data),
        .Wr_Req   (Wr_Req),
        .Wr_Dev   (Wr_Dev),
        .Wr_Reg   (Wr_Reg),
        .Wr_Data  (Wr_Data),
        .Wr_Ack   (Wr_Ack),
        .Wr_Done  (Wr_Done),
        .Wr_Nack  (Wr_Nack),
        .Busy     (Busy),
        .Init_Done(Init_Done),
        .Init_Err (Init_Err),
        .Err_Index(Err_Index)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Table ROM with a one-cycle registered read.
    initial begin
        logic [IDX_W-1:0] a;
        Tbl_Data = 16'h0000;
        forever begin
            @(posedge Clk);
            a = Tbl_Addr;
            #1 Tbl_Data = tbl[a];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    task automatic push_entry(input int k, input logic nack, input logic same);
        exp_t x;
        x.r    = tbl[k][15:8];
        x.d    = tbl[k][7:0];
        x.nack = nack;
        x.same = same;
        exp_q.push_back(x);
    endtask

    task automatic pulse_go();
        Go = 1'b1;
        @(negedge Clk);
        Go = 1'b0;
    endtask

    task automatic wait_req(output logic okv, output int cyc);
        cyc = 0;
        while (!Wr_Req && cyc < TMO) begin
            @(negedge Clk);
            cyc++;
        end
        okv = Wr_Req;
    endtask

    task automatic wait_idle(output logic okv);
        int c;
        c = 0;
        while (Busy && c < TMO) begin
            @(negedge Clk);
            c++;
        end
        okv = !Busy;
    endtask

    // Engine model: ack after ACK_DLY cycles, done DONE_DLY cycles later,
    // or ack and done together when same is set.
    task automatic respond(input logic nack, input logic same);
        repeat (ACK_DLY - 1) @(negedge Clk);
        Wr_Ack = 1'b1;
        if (same) begin
            Wr_Done = 1'b1;
            Wr_Nack = nack;
        end
        @(negedge Clk);
        Wr_Ack  = 1'b0;
        Wr_Done = 1'b0;
        Wr_Nack = 1'b0;
        if (!same) begin
            repeat (DONE_DLY - 1) @(negedge Clk);
            Wr_Done = 1'b1;
            Wr_Nack = nack;
            @(negedge Clk);
            Wr_Done = 1'b0;
            Wr_Nack = 1'b0;
        end
    endtask

    task automatic test_reset();
        Rst_n   = 1'b0;
        Go      = 1'b0;
        Wr_Ack  = 1'b0;
        Wr_Done = 1'b0;
        Wr_Nack = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Wr_Req, Busy, Init_Done, Init_Err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: req/busy/done/err=%b, required 0000",
                     {Wr_Req, Busy, Init_Done, Init_Err});
        end
        checks++;
        if (Tbl_Addr !== '0 || Wr_Reg !== 8'h00 || Wr_Data !== 8'h00 || Err_Index !== '0) begin
            errors++;
            $display("FAIL reset_regs: addr=%h reg=%h data=%h eidx=%h, required all 0",
                     Tbl_Addr, Wr_Reg, Wr_Data, Err_Index);
        end
        checks++;
        if (Wr_Dev !== DEV_ADDR) begin
            errors++;
            $display("FAIL reset_dev: Wr_Dev=%h, required %h", Wr_Dev, DEV_ADDR);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Wr_Req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_go: busy=%b req=%b, required 0 0", Busy, Wr_Req);
        end
    endtask

    task automatic test_basic();
        for (int k = 0; k < NUM_REGS; k++) push_entry(k, 1'b0, 1'b0);
        pulse_go();
        checks++;
        if (Busy !== 1'b1 || Tbl_Addr !== '0) begin
            errors++;
            $display("FAIL basic_go: busy=%b addr=%0d, required 1 0", Busy, Tbl_Addr);
        end
        while (exp_q.size() > 0) begin
            wait_req(ok, n);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL basic_req_timeout: Wr_Req=%b after %0d cycles, required 1", Wr_Req, n);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                if ({Wr_Reg, Wr_Data} !== {e.r, e.d}) begin
                    errors++;
                    $display("FAIL basic_req: reg/data=%h/%h, required %h/%h", Wr_Reg, Wr_Data, e.r, e.d);
                end
                $display("txn basic: reg=%h data=%h nack=%b", Wr_Reg, Wr_Data, e.nack);
                respond(e.nack, e.same);
            end
        end
        // Last write done: exactly GAP_CYCLES busy cycles, then DONE.
        for (int i = 0; i < GAP_CYCLES; i++) begin
            checks++;
            if (Busy !== 1'b1 || Init_Done !== 1'b0) begin
                errors++;
                $display("FAIL basic_gap%0d: busy=%b done=%b, required 1 0", i, Busy, Init_Done);
            end
            @(negedge Clk);
        end
        checks++;
        if (Busy !== 1'b0 || Init_Done !== 1'b1 || Init_Err !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: busy=%b done=%b err=%b, required 0 1 0", Busy, Init_Done, Init_Err);
        end
        // Stray engine pulses in DONE must be ignored.
        Wr_Ack  = 1'b1;
        Wr_Done = 1'b1;
        Wr_Nack = 1'b1;
        @(negedge Clk);
        Wr_Ack  = 1'b0;
        Wr_Done = 1'b0;
        Wr_Nack = 1'b0;
        repeat (2) @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Init_Done !== 1'b1 || Init_Err !== 1'b0 || Wr_Req !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: busy=%b done=%b err=%b req=%b, required 0 1 0 0",
                     Busy, Init_Done, Init_Err, Wr_Req);
        end
    endtask

    task automatic test_retry();
        push_entry(0, 1'b0, 1'b0);
        push_entry(1, 1'b1, 1'b0);
        push_entry(1, 1'b1, 1'b0);
        push_entry(1, 1'b0, 1'b0);
        push_entry(2, 1'b0, 1'b0);
        push_entry(3, 1'b0, 1'b0);
        pulse_go();
        while (exp_q.size() > 0) begin
            wait_req(ok, n);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL retry_req_timeout: Wr_Req=%b after %0d cycles, required 1", Wr_Req, n);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                if ({Wr_Reg, Wr_Data} !== {e.r, e.d}) begin
                    errors++;
                    $display("FAIL retry_req: reg/data=%h/%h, required %h/%h", Wr_Reg, Wr_Data, e.r, e.d);
                end
                $display("txn retry: reg=%h data=%h nack=%b", Wr_Reg, Wr_Data, e.nack);
                respond(e.nack, e.same);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || Init_Done !== 1'b1 || Init_Err !== 1'b0) begin
            errors++;
            $display("FAIL retry_done: idle=%b done=%b err=%b, required 1 1 0", ok, Init_Done, Init_Err);
        end
    endtask

    task automatic test_error();
        push_entry(0, 1'b0, 1'b0);
        push_entry(1, 1'b0, 1'b0);
        for (int i = 0; i <= MAX_RETRY; i++) push_entry(2, 1'b1, 1'b0);
        pulse_go();
        checks++;
        if (Init_Done !== 1'b0) begin
            errors++;
            $display("FAIL error_go_clear: done=%b, required 0", Init_Done);
        end
        while (exp_q.size() > 0) begin
            wait_req(ok, n);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL error_req_timeout: Wr_Req=%b after %0d cycles, required 1", Wr_Req, n);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                if ({Wr_Reg, Wr_Data} !== {e.r, e.d}) begin
                    errors++;
                    $display("FAIL error_req: reg/data=%h/%h, required %h/%h", Wr_Reg, Wr_Data, e.r, e.d);
                end
                $display("txn error: reg=%h data=%h nack=%b", Wr_Reg, Wr_Data, e.nack);
                respond(e.nack, e.same);
            end
        end
        checks++;
        if (Init_Err !== 1'b1 || Err_Index !== 6'd2 || Init_Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL error_state: err=%b eidx=%0d done=%b busy=%b, required 1 2 0 0",
                     Init_Err, Err_Index, Init_Done, Busy);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge Clk);
            if (Wr_Req === 1'b1 || Init_Err !== 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL error_hold: extra request or lost error=%b, required 0", seen);
        end
    endtask

    task automatic test_go_busy();
        for (int k = 0; k < NUM_REGS; k++) push_entry(k, 1'b0, 1'b0);
        pulse_go();
        checks++;
        if (Init_Err !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL gobusy_start: err=%b busy=%b, required 0 1", Init_Err, Busy);
        end
        pulse_en = 1'b1;
        fork
            begin
                while (exp_q.size() > 0) begin
                    wait_req(ok, n);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL gobusy_req_timeout: Wr_Req=%b after %0d cycles, required 1", Wr_Req, n);
                        exp_q.delete();
                    end else begin
                        e = exp_q.pop_front();
                        if ({Wr_Reg, Wr_Data} !== {e.r, e.d}) begin
                            errors++;
                            $display("FAIL gobusy_req: reg/data=%h/%h, required %h/%h", Wr_Reg, Wr_Data, e.r, e.d);
                        end
                        $display("txn gobusy: reg=%h data=%h nack=%b", Wr_Reg, Wr_Data, e.nack);
                        respond(e.nack, e.same);
                    end
                end
                pulse_en = 1'b0;
            end
            begin
                while (pulse_en) begin
                    repeat ($urandom_range(2, 9)) @(negedge Clk);
                    if (pulse_en && Busy) begin
                        Go = 1'b1;
                        @(negedge Clk);
                        Go = 1'b0;
                    end
                end
            end
        join
        wait_idle(ok);
        checks++;
        if (!ok || Init_Done !== 1'b1 || Init_Err !== 1'b0) begin
            errors++;
            $display("FAIL gobusy_done: idle=%b done=%b err=%b, required 1 1 0", ok, Init_Done, Init_Err);
        end
        // Go in DONE restarts from entry 0.
        @(negedge Clk);
        pulse_go();
        checks++;
        if (Init_Done !== 1'b0 || Busy !== 1'b1 || Tbl_Addr !== '0) begin
            errors++;
            $display("FAIL restart_go: done=%b busy=%b addr=%0d, required 0 1 0", Init_Done, Busy, Tbl_Addr);
        end
        for (int k = 0; k < NUM_REGS; k++) push_entry(k, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            wait_req(ok, n);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL restart_req_timeout: Wr_Req=%b after %0d cycles, required 1", Wr_Req, n);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                if ({Wr_Reg, Wr_Data} !== {e.r, e.d}) begin
                    errors++;
                    $display("FAIL restart_req: reg/data=%h/%h, required %h/%h", Wr_Reg, Wr_Data, e.r, e.d);
                end
                $display("txn restart: reg=%h data=%h nack=%b", Wr_Reg, Wr_Data, e.nack);
                respond(e.nack, e.same);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || Init_Done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: idle=%b done=%b, required 1 1", ok, Init_Done);
        end
    endtask

    task automatic test_async_reset();
        pulse_go();
        wait_req(ok, n);
        checks++;
        if (!ok || {Wr_Reg, Wr_Data} !== tbl[0]) begin
            errors++;
            $display("FAIL areset_pre: req=%b reg/data=%h%h, required 1 %h", ok, Wr_Reg, Wr_Data, tbl[0]);
        end
        $display("txn areset: reg=%h data=%h dropped by reset", Wr_Reg, Wr_Data);
        #2 Rst_n = 1'b0;
        #1;
        checks++;
        if ({Wr_Req, Busy, Init_Done, Init_Err} !== 4'b0000 || Tbl_Addr !== '0 ||
            Wr_Reg !== 8'h00 || Wr_Data !== 8'h00 || Err_Index !== '0) begin
            errors++;
            $display("FAIL areset_outputs: req/busy/done/err=%b addr=%h reg=%h data=%h eidx=%h, required all 0",
                     {Wr_Req, Busy, Init_Done, Init_Err}, Tbl_Addr, Wr_Reg, Wr_Data, Err_Index);
        end
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        for (int k = 0; k < NUM_REGS; k++) push_entry(k, 1'b0, 1'b0);
        pulse_go();
        while (exp_q.size() > 0) begin
            wait_req(ok, n);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL areset_req_timeout: Wr_Req=%b after %0d cycles, required 1", Wr_Req, n);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                if ({Wr_Reg, Wr_Data} !== {e.r, e.d}) begin
                    errors++;
                    $display("FAIL areset_req: reg/data=%h/%h, required %h/%h", Wr_Reg, Wr_Data, e.r, e.d);
                end
                $display("txn areset: reg=%h data=%h nack=%b", Wr_Reg, Wr_Data, e.nack);
                respond(e.nack, e.same);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || Init_Done !== 1'b1 || Init_Err !== 1'b0) begin
            errors++;
            $display("FAIL areset_done: idle=%b done=%b err=%b, required 1 1 0", ok, Init_Done, Init_Err);
        end
    endtask

    task automatic test_same_cycle();
        int exp_n;
        for (int k = 0; k < NUM_REGS; k++) push_entry(k, 1'b0, 1'b1);
        pulse_go();
        exp_n = 2;
        while (exp_q.size() > 0) begin
            wait_req(ok, n);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL same_req_timeout: Wr_Req=%b after %0d cycles, required 1", Wr_Req, n);
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                if ({Wr_Reg, Wr_Data} !== {e.r, e.d}) begin
                    errors++;
                    $display("FAIL same_req: reg/data=%h/%h, required %h/%h", Wr_Reg, Wr_Data, e.r, e.d);
                end
                checks++;
                if (n !== exp_n) begin
                    errors++;
                    $display("FAIL same_latency: %0d cycles to Wr_Req, required %0d", n, exp_n);
                end
                $display("txn same: reg=%h data=%h wait=%0d", Wr_Reg, Wr_Data, n);
                respond(e.nack, e.same);
                exp_n = GAP_CYCLES + 2;
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok || Init_Done !== 1'b1 || Tbl_Addr !== 6'(NUM_REGS - 1)) begin
            errors++;
            $display("FAIL same_done: idle=%b done=%b addr=%0d, required 1 1 %0d",
                     ok, Init_Done, Tbl_Addr, NUM_REGS - 1);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << IDX_W); i++) tbl[i] = 16'h0000;
        tbl[0] = 16'h0830;
        tbl[1] = 16'h2B80;
        tbl[2] = 16'h0050;
        tbl[3] = 16'h1922;
        pulse_en = 1'b0;
        seen     = 1'b0;
        test_reset();
        test_basic();
        test_retry();
        test_error();
        test_go_busy();
        test_async_reset();
        test_same_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
